// File: rtl/reg_scoreboard_pkg.sv
// Shared types and constants for the write-tracking scoreboard.
package reg_scoreboard_pkg;

  localparam int unsigned REG_IDX_W       = 2;
  localparam int unsigned DEFAULT_DEPTH   = 3;
  localparam int unsigned STAT_W          = 16;
  localparam int unsigned DEFAULT_NUM_REG = 4;

  // One in-flight instruction record
  typedef struct packed {
    logic                 writes;
    logic [REG_IDX_W-1:0] dest;
  } sb_entry_t;

endpackage

// File: rtl/reg_scoreboard_sb_entry_fifo.sv
// sb_entry_fifo: in-order record FIFO for reg_scoreboard. Exposes every slot
// with its valid bit so the parent can compare all in-flight writes at once.
// DEPTH need not be a power of two; pointers wrap explicitly.
module sb_entry_fifo
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  sb_entry_t             push_entry,
  output logic [DEPTH-1:0]      entry_valid,
  output sb_entry_t [DEPTH-1:0] entries,
  output logic [PTR_W-1:0]      head_ptr,
  output logic [CNT_W-1:0]      count
);

  logic [PTR_W-1:0] tail_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer, occupancy and slot update; pop clears before push so a full
  // push+pop into the same slot leaves it valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr    <= '0;
      tail_ptr    <= '0;
      count       <= '0;
      entry_valid <= '0;
      entries     <= '0;
    end else begin
      if (pop) begin
        entry_valid[head_ptr] <= 1'b0;
        head_ptr              <= next_ptr(head_ptr);
      end
      if (push) begin
        entry_valid[tail_ptr] <= 1'b1;
        entries[tail_ptr]     <= push_entry;
        tail_ptr              <= next_ptr(tail_ptr);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks destinations of instructions between ID->EX issue
// and WB retire, and stalls decode on a pending write the register file's
// same-cycle bypass cannot cover.
// Optional feature macro: SCOREBOARD_STATS_EN adds the stall_cycles counter.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REG = DEFAULT_NUM_REG,
  parameter int unsigned DEPTH   = DEFAULT_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  input  logic       issue_writes,
  input  logic [1:0] issue_dest,
  input  logic [1:0] src1,
  input  logic [1:0] src2,
  input  logic       use_src1,
  input  logic       use_src2,
  input  logic       wb_retire,
  input  logic       wb_write,
  input  logic [1:0] wb_dest,
  output logic       stall,
  output logic [1:0] count,
  output logic       err
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cycles
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;

  logic [DEPTH-1:0]      entry_valid;
  sb_entry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0]      head_ptr;
  logic [CNT_W-1:0]      fifo_count;
  sb_entry_t             head_entry;
  sb_entry_t             push_entry;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  bypass;
  logic                  haz1;
  logic                  haz2;
  logic                  push;
  logic                  pop;
  logic                  err_event;

  sb_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .push_entry  (push_entry),
    .entry_valid (entry_valid),
    .entries     (entries),
    .head_ptr    (head_ptr),
    .count       (fifo_count)
  );

  assign head_entry = entries[head_ptr];
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(DEPTH));
  assign count      = 2'(fifo_count);
  assign push_entry = '{writes: issue_writes, dest: issue_dest};

  // Parallel source compare; the retiring head is skipped when it writes
  // this cycle since the register file forwards that value.
  always_comb begin
    haz1   = 1'b0;
    haz2   = 1'b0;
    bypass = wb_retire && wb_write && !fifo_empty;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      if (entry_valid[e] && entries[e].writes &&
          !(bypass && (PTR_W'(e) == head_ptr))) begin
        if (use_src1 && (entries[e].dest[IDX_W-1:0] == src1[IDX_W-1:0])) haz1 = 1'b1;
        if (use_src2 && (entries[e].dest[IDX_W-1:0] == src2[IDX_W-1:0])) haz2 = 1'b1;
      end
    end
  end

  // Stall, accepted push/pop and protocol-error detection
  always_comb begin
    stall     = !reset && (haz1 || haz2 || (fifo_full && !wb_retire));
    push      = !reset && issue_valid && !stall;
    pop       = !reset && wb_retire && !fifo_empty;
    err_event = (issue_valid && stall) ||
                (wb_retire && fifo_empty) ||
                (wb_retire && wb_write && !fifo_empty &&
                 (!head_entry.writes || (head_entry.dest != wb_dest)));
  end

  // Sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (err_event) begin
      err <= 1'b1;
    end
  end

`ifdef SCOREBOARD_STATS_EN
  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != {STAT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: a driver applies directed vectors and
// queues the hand-computed expectations; a monitor compares each cycle.
// Expected count/err are the values visible during the vector's cycle
// (state from the previous edge); stall is for that cycle's inputs.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0, issue_writes = 1'b0;
  logic [1:0]  issue_dest = 2'd0, src1 = 2'd0, src2 = 2'd0, wb_dest = 2'd0;
  logic        use_src1 = 1'b0, use_src2 = 1'b0, wb_retire = 1'b0, wb_write = 1'b0;
  logic        stall, err;
  logic [1:0]  count;
`ifdef SCOREBOARD_STATS_EN
  logic [15:0] stall_cycles;
`endif

  reg_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_writes (issue_writes),
    .issue_dest   (issue_dest),
    .src1         (src1),
    .src2         (src2),
    .use_src1     (use_src1),
    .use_src2     (use_src2),
    .wb_retire    (wb_retire),
    .wb_write     (wb_write),
    .wb_dest      (wb_dest),
    .stall        (stall),
    .count        (count),
    .err          (err)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall;
    logic [1:0]  count;
    logic        err;
    logic [15:0] stats;
    logic [3:0]  mask;  // bit0 stall, bit1 count, bit2 err, bit3 stats
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [3:0] M_ALL = 4'b0111;
  localparam logic [3:0] M_ST  = 4'b0001;
`ifdef SCOREBOARD_STATS_EN
  localparam logic [3:0] M_STAT = 4'b1111;
`else
  localparam logic [3:0] M_STAT = 4'b0111;
`endif

  // Inputs: {rst, iv, iw, id, s1, u1, s2, u2, wr, ww, wd}
  task automatic vec(input string name, input logic rst, input logic iv, input logic iw,
                     input logic [1:0] id, input logic [1:0] s1, input logic u1,
                     input logic [1:0] s2, input logic u2, input logic wr, input logic ww,
                     input logic [1:0] wd, input logic es, input logic [1:0] ec,
                     input logic ee, input logic [15:0] est, input logic [3:0] mask);
    exp_t x;
    @(negedge clk);
    #1;
    reset = rst; issue_valid = iv; issue_writes = iw; issue_dest = id;
    src1 = s1; use_src1 = u1; src2 = s2; use_src2 = u2;
    wb_retire = wr; wb_write = ww; wb_dest = wd;
    x.name = name; x.stall = es; x.count = ec; x.err = ee; x.stats = est; x.mask = mask;
    exp_q.push_back(x);
  endtask

  // Monitor: compare mid-cycle, after inputs settle and well before posedge
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        if (x.mask[0]) begin
          total++;
          if (stall !== x.stall) begin
            bad++;
            $display("FAIL %s stall: got %0b want %0b", x.name, stall, x.stall);
          end
        end
        if (x.mask[1]) begin
          total++;
          if (count !== x.count) begin
            bad++;
            $display("FAIL %s count: got %0d want %0d", x.name, count, x.count);
          end
        end
        if (x.mask[2]) begin
          total++;
          if (err !== x.err) begin
            bad++;
            $display("FAIL %s err: got %0b want %0b", x.name, err, x.err);
          end
        end
`ifdef SCOREBOARD_STATS_EN
        if (x.mask[3]) begin
          total++;
          if (stall_cycles !== x.stats) begin
            bad++;
            $display("FAIL %s stall_cycles: got %0h want %0h", x.name, stall_cycles, x.stats);
          end
        end
`endif
      end
    end
  end

  // Driver: directed vectors
  initial begin
    int wait_cycles;
    //   name          rst iv iw id  s1 u1 s2 u2 wr ww wd   stall cnt err stats   mask
    vec("rst_in",       1, 1, 1, 1,  1, 1, 1, 1, 1, 1, 1,  0, 0, 0, 0, M_ST);
    vec("rst_hold",     1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, M_ALL);
    vec("idle",         0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, M_ALL);
    // RAW on r1: two stalled cycles, then bypass on retire
    vec("iss_r1",       0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, M_ALL);
    vec("raw_ex",       0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, M_ALL);
    vec("raw_mem",      0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, M_ALL);
    vec("raw_bypass",   0, 1, 1, 2,  1, 1, 0, 0, 1, 1, 1,  0, 1, 0, 0, M_ALL);
    vec("after_swap",   0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, M_ALL);
    vec("ret_r2",       0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 2,  0, 1, 0, 0, M_ALL);
    vec("empty",        0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, M_ALL);
    // Fill to DEPTH, then push+pop while full
    vec("fill0",        0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, M_ALL);
    vec("fill1",        0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, M_ALL);
    vec("fill2",        0, 1, 1, 3,  0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 0, M_ALL);
    vec("full",         0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  1, 3, 0, 0, M_ALL);
    vec("full_pushpop", 0, 1, 1, 1,  0, 0, 0, 0, 1, 1, 0,  0, 3, 0, 0, M_ALL);
    vec("haz_r3",       0, 0, 0, 0,  3, 1, 0, 0, 0, 0, 0,  1, 3, 0, 0, M_ALL);
    vec("ret_nowr",     0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0,  0, 3, 0, 0, M_ALL);
    vec("haz_src2",     0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0,  1, 2, 0, 0, M_ALL);
    vec("bypass_s1",    0, 0, 0, 0,  3, 1, 0, 0, 1, 1, 3,  0, 2, 0, 0, M_ALL);
    vec("bypass_s2",    0, 0, 0, 0,  0, 0, 1, 1, 1, 1, 1,  0, 1, 0, 0, M_ALL);
    // Retire on empty: sticky error
    vec("ret_empty",    0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, M_ALL);
    vec("err_set",      0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, M_ALL);
    vec("err_sticky0",  0, 1, 1, 2,  0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, M_ALL);
    vec("err_sticky1",  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, M_ALL);
    vec("rst_err",      1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, M_ALL);
    vec("err_clear",    0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, M_ALL);
    // Wrong retire destination: error, pop still happens
    vec("iss_r2",       0, 1, 1, 2,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, M_ALL);
    vec("ret_wrongd",   0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 3,  0, 1, 0, 0, M_ALL);
    vec("wrongd_res",   0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, M_ALL);
    // Issue while stalled: ignored, error
    vec("rst2",         1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, M_ALL);
    vec("iss_r1b",      0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, M_ALL);
    vec("iss_stalled",  0, 1, 1, 0,  1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, M_ALL);
    vec("ign_res",      0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, M_ALL);
    // Mid-operation reset flushes entries and masks stall
    vec("rst_mid",      1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0,  0, 1, 1, 0, M_ALL);
    vec("flushed",      0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, M_ALL);
    // Stall statistics: five stalled cycles
    vec("rst3",         1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, M_ALL);
    vec("st_iss",       0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, M_STAT);
    for (int i = 0; i < 5; i++)
      vec("st_stall",   0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 16'(i), M_STAT);
    vec("st_five",      0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 16'd5, M_STAT);
    vec("st_ret",       0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 1,  0, 1, 0, 16'd5, M_STAT);
`ifdef SCOREBOARD_STATS_EN
    // Preload near saturation, then stall past the top
    @(negedge clk);
    dut.stall_cycles = 16'hFFFD;
    vec("sat_iss",      0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 16'hFFFD, M_STAT);
    vec("sat_s0",       0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 16'hFFFD, M_STAT);
    vec("sat_s1",       0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 16'hFFFE, M_STAT);
    vec("sat_s2",       0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 16'hFFFF, M_STAT);
    vec("sat_s3",       0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 16'hFFFF, M_STAT);
    vec("sat_hold",     0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 16'hFFFF, M_STAT);
`endif
    vec("drain",        0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, M_ST);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL monitor_drain: got %0d pending want 0", exp_q.size());
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
